// File: rtl/sprite_fetch_sched_pkg.sv
// Shared definitions for the sprite fetch scheduler: FSM state encoding,
// default geometry and the sprite index width helper.
package sprite_fetch_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_NUM_SPRITES   = 5;
  localparam int SPRITE_ADDR_WIDTH = 9;
  localparam int DEF_RD_LATENCY    = 2;

  // A single sprite still needs a 1-bit index so vectors never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_prio_pick.sv
// Combinational picker: first set bit of i_pending searching upward from i_base,
// wrapping modulo NUM_SPRITES. No state, no latency.
module sprite_prio_pick #(
  parameter int NUM_SPRITES = 5,
  parameter int IDX_W       = 3
) (
  input  logic [NUM_SPRITES-1:0] i_pending,
  input  logic [IDX_W-1:0]       i_base,
  output logic                   o_found,
  output logic [IDX_W-1:0]       o_index
);

  int               w_j;
  logic [IDX_W-1:0] w_jx;

  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_j     = 0;
    w_jx    = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      w_j = int'(i_base) + i;
      if (w_j >= NUM_SPRITES) begin
        w_j = w_j - NUM_SPRITES;
      end
      w_jx = IDX_W'(w_j);
      if (!o_found && i_pending[w_jx]) begin
        o_found = 1'b1;
        o_index = w_jx;
      end
    end
  end

endmodule

// File: rtl/sprite_fetch_sched.sv
// Per-scanline sprite RAM read scheduler; one grant per requester, load_en RD_LATENCY after address.
// Stalls issuing while loading_loc is high; SPRITE_FETCH_RR_EN selects rotating priority.
module sprite_fetch_sched
  import sprite_fetch_sched_pkg::*;
#(
  parameter int NUM_SPRITES = DEF_NUM_SPRITES,
  parameter int ADDR_WIDTH  = SPRITE_ADDR_WIDTH,
  parameter int RD_LATENCY  = DEF_RD_LATENCY
) (
  input  logic                              px_clk,
  input  logic                              px_rst,
  input  logic                              linebegin,
  input  logic                              loading_loc,
  input  logic [NUM_SPRITES-1:0]            req,
  input  logic [NUM_SPRITES*ADDR_WIDTH-1:0] mem_addr_in,
  output logic [ADDR_WIDTH-1:0]             mem_addr_out,
  output logic [NUM_SPRITES-1:0]            load_en,
  output logic                              fetch_done,
  output logic                              busy,
  output logic                              overrun,
  input  logic                              overrun_clr
);

  localparam int IDX_W = idx_width(NUM_SPRITES);

  state_t                  r_state;
  logic [NUM_SPRITES-1:0]  r_pending;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_fetch_done;
  logic                    r_overrun;
  logic [NUM_SPRITES-1:0]  r_load_en;
  logic [RD_LATENCY-1:0]   r_pipe_vld;
  logic [IDX_W-1:0]        r_pipe_idx [RD_LATENCY];

  logic                    w_start;
  logic [NUM_SPRITES-1:0]  w_cand;
  logic                    w_can_issue;
  logic                    w_found;
  logic [IDX_W-1:0]        w_idx;
  logic [IDX_W-1:0]        w_base;
  logic                    w_issue;
  logic [NUM_SPRITES-1:0]  w_grant;
  logic [NUM_SPRITES-1:0]  w_pend_next;
  logic [ADDR_WIDTH-1:0]   w_addr_sel;
  logic [NUM_SPRITES-1:0]  w_le_next;
  logic                    w_pipe_empty;

  // The first grant happens on the linebegin edge itself, so address 0 shows in N+1.
  assign w_start     = linebegin && (r_state == ST_IDLE);
  assign w_cand      = w_start ? req : r_pending;
  assign w_can_issue = (w_start || (r_state == ST_ISSUE)) && !loading_loc;
  assign w_issue     = w_can_issue && w_found;
  assign w_pend_next = w_issue ? (w_cand & ~w_grant) : w_cand;
  assign w_pipe_empty = (r_pipe_vld == '0);

  sprite_prio_pick #(
    .NUM_SPRITES (NUM_SPRITES),
    .IDX_W       (IDX_W)
  ) u_pick (
    .i_pending (w_cand),
    .i_base    (w_base),
    .o_found   (w_found),
    .o_index   (w_idx)
  );

  always_comb begin
    w_grant    = '0;
    w_grant[w_idx] = 1'b1;
    w_addr_sel = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_addr_sel = mem_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
    w_le_next = '0;
    if (r_pipe_vld[RD_LATENCY-1]) begin
      w_le_next[r_pipe_idx[RD_LATENCY-1]] = 1'b1;
    end
  end

  always_ff @(posedge px_clk or posedge px_rst) begin
    if (px_rst) begin
      r_state      <= ST_IDLE;
      r_pending    <= '0;
      r_addr       <= '0;
      r_fetch_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_fetch_done <= 1'b0;
      if (w_issue) begin
        r_addr <= w_addr_sel;
      end
      if (overrun_clr) begin
        r_overrun <= 1'b0;
      end else if (linebegin && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (linebegin) begin
            r_pending <= w_pend_next;
            if (req == '0) begin
              r_state      <= ST_DONE;
              r_fetch_done <= 1'b1;
            end else if (w_pend_next == '0) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_pending <= w_pend_next;
          if (w_pend_next == '0) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pipe_empty) begin
            r_state      <= ST_DONE;
            r_fetch_done <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-return pipe: stage 0 lines up with the address cycle, load_en is one register past the end.
  always_ff @(posedge px_clk or posedge px_rst) begin
    if (px_rst) begin
      r_pipe_vld <= '0;
      r_load_en  <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pipe_idx[i] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= w_issue;
      r_pipe_idx[0] <= w_idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end
      r_load_en <= w_le_next;
    end
  end

`ifdef SPRITE_FETCH_RR_EN
  logic [IDX_W-1:0] r_base;
  logic [IDX_W-1:0] r_first;
  logic             r_first_vld;

  assign w_base = r_base;

  always_ff @(posedge px_clk or posedge px_rst) begin
    if (px_rst) begin
      r_base      <= '0;
      r_first     <= '0;
      r_first_vld <= 1'b0;
    end else begin
      if (w_issue && (w_start || !r_first_vld)) begin
        r_first     <= w_idx;
        r_first_vld <= 1'b1;
      end else if (w_start) begin
        r_first_vld <= 1'b0;
      end
      // An empty line grants nothing and leaves the rotation where it was.
      if ((r_state == ST_DONE) && r_first_vld) begin
        r_base <= (r_first == IDX_W'(NUM_SPRITES - 1)) ? '0 : r_first + 1'b1;
      end
    end
  end
`else
  assign w_base = '0;
`endif

  assign mem_addr_out = r_addr;
  assign load_en      = r_load_en;
  assign fetch_done   = r_fetch_done;
  assign busy         = (r_state != ST_IDLE);
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_sprite_fetch_sched.sv
// Self-checking bench for sprite_fetch_sched: table of scanline vectors plus
// reset and overrun sequences, with queued expectations compared at negedge.
module tb_sprite_fetch_sched;

  localparam int NS  = 5;
  localparam int AW  = 9;
  localparam int RDL = 2;

  logic             px_clk;
  logic             px_rst;
  logic             linebegin;
  logic             loading_loc;
  logic [NS-1:0]    req;
  logic [NS*AW-1:0] mem_addr_in;
  logic [AW-1:0]    mem_addr_out;
  logic [NS-1:0]    load_en;
  logic             fetch_done;
  logic             busy;
  logic             overrun;
  logic             overrun_clr;

  sprite_fetch_sched #(
    .NUM_SPRITES (NS),
    .ADDR_WIDTH  (AW),
    .RD_LATENCY  (RDL)
  ) dut (
    .px_clk       (px_clk),
    .px_rst       (px_rst),
    .linebegin    (linebegin),
    .loading_loc  (loading_loc),
    .req          (req),
    .mem_addr_in  (mem_addr_in),
    .mem_addr_out (mem_addr_out),
    .load_en      (load_en),
    .fetch_done   (fetch_done),
    .busy         (busy),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  typedef struct {
    logic [4:0] req;
    int         st_lo;
    int         st_hi;
    int         lb2;
    int         clr;
    int         cnt;
    int         fd;
    logic       ovr;
  } vec_t;

  typedef struct {
    int c;
    int v;
  } ev_t;

  ev_t  q_le[$];
  ev_t  q_addr[$];
  ev_t  q_fd[$];
  vec_t vecs[9];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   le_tot = 0;
  int   busy_tot = 0;
  int   salt = 0;
  int   mbase = 0;

  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;
  always @(posedge px_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [8:0] addr_of(input int s, input int k);
    return 9'((s * 7 + k * 37 + 5) % 512);
  endfunction

  function automatic int mpick(input logic [4:0] p, input int b);
    for (int i = 0; i < NS; i++) begin
      if (p[(b + i) % NS]) return (b + i) % NS;
    end
    return 0;
  endfunction

  task automatic set_addrs(input int s);
    for (int k = 0; k < NS; k++) mem_addr_in[k*AW +: AW] = addr_of(s, k);
  endtask

  // Compare every queued expectation whose cycle has come, then move past the next edge.
  task automatic sample();
    ev_t e;
    if (busy) busy_tot++;
    if (load_en != '0) begin
      le_tot++;
      if (q_le.size() == 0) chk("le_unexpected", 32'(load_en), 0);
      else begin
        e = q_le.pop_front();
        chk("le_cycle", cyc, e.c);
        chk("le_onehot", 32'(load_en), e.v);
      end
    end
    if (fetch_done) begin
      if (q_fd.size() == 0) chk("fd_unexpected", 32'(fetch_done), 0);
      else begin
        e = q_fd.pop_front();
        chk("fd_cycle", cyc, e.c);
      end
    end
    if (q_addr.size() > 0 && q_addr[0].c == cyc) begin
      e = q_addr.pop_front();
      chk("addr", 32'(mem_addr_out), e.v);
    end
  endtask

  task automatic tick();
    @(negedge px_clk);
    sample();
    @(posedge px_clk);
    #1;
  endtask

  task automatic model_line(input int n, input vec_t v, input int cut);
    logic [4:0] p;
    logic [8:0] cur;
    int dc, k, first;
    bit any;
    p = v.req; dc = n; first = -1; any = 1'b0; cur = '0;
    while (p != '0 && dc < n + 64) begin
      if (!((dc - n) >= v.st_lo && (dc - n) <= v.st_hi)) begin
        k = mpick(p, mbase);
        p[k] = 1'b0;
        if (first < 0) first = k;
        cur = addr_of((dc == n) ? salt : salt + 1, k);
        any = 1'b1;
        if (dc + 1 + RDL < cut) q_le.push_back('{dc + 1 + RDL, 1 << k});
      end
      if (any && dc + 1 < cut) q_addr.push_back('{dc + 1, int'(cur)});
      dc++;
    end
    if (n + v.fd < cut) q_fd.push_back('{n + v.fd, 1});
`ifdef SPRITE_FETCH_RR_EN
    if (first >= 0) mbase = (first + 1) % NS;
`endif
  endtask

  task automatic drive(input int t, input vec_t v);
    linebegin   = (t == 0) || (t == v.lb2);
    overrun_clr = (t == v.clr);
    loading_loc = (t >= v.st_lo) && (t <= v.st_hi);
    req         = (t == 0) ? v.req : ~v.req;
    if (t == 1) set_addrs(salt + 1);
  endtask

  task automatic idle_inputs();
    linebegin = 1'b0; overrun_clr = 1'b0; loading_loc = 1'b0; req = '0;
  endtask

  task automatic run_line(input vec_t v);
    int n, le0, bz0;
    set_addrs(salt);
    tick();
    n = cyc + 1;
    model_line(n, v, n + 1000);
    le0 = le_tot; bz0 = busy_tot;
    for (int t = 0; t <= v.fd + 3; t++) begin
      tick();
      drive(t, v);
    end
    idle_inputs();
    chk("le_count", le_tot - le0, v.cnt);
    chk("busy_cycles", busy_tot - bz0, v.fd);
    chk("exp_drained", q_le.size() + q_addr.size() + q_fd.size(), 0);
    chk("overrun", 32'(overrun), 32'(v.ovr));
    if (overrun) begin
      tick(); overrun_clr = 1'b1;
      tick(); overrun_clr = 1'b0;
      chk("overrun_clr", 32'(overrun), 0);
    end
    salt += 2;
  endtask

  initial begin
    int n;
    //            req      st_lo st_hi lb2 clr cnt fd ovr
    vecs[0] = '{5'b10110, 99, -1, -1, -1, 3,  6, 1'b0};
    vecs[1] = '{5'b00000, 99, -1, -1, -1, 0,  1, 1'b0};
    vecs[2] = '{5'b11111,  2,  4, -1, -1, 5, 11, 1'b0};
    vecs[3] = '{5'b11111, 99, -1, -1, -1, 5,  8, 1'b0};
    vecs[4] = '{5'b00001, 99, -1, -1, -1, 1,  4, 1'b0};
    vecs[5] = '{5'b10000,  0,  1, -1, -1, 1,  6, 1'b0};
    vecs[6] = '{5'b11111, 99, -1,  2, -1, 5,  8, 1'b1};
    vecs[7] = '{5'b01010, 99, -1,  3,  3, 2,  5, 1'b0};
    vecs[8] = '{5'b01000,  1,  3, -1, -1, 1,  4, 1'b0};

    px_rst = 1'b1;
    idle_inputs();
    set_addrs(0);
    repeat (3) tick();
    chk("rst_addr", 32'(mem_addr_out), 0);
    chk("rst_load_en", 32'(load_en), 0);
    chk("rst_fetch_done", 32'(fetch_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    px_rst = 1'b0;
    while (cyc < 8) tick();

    for (int i = 0; i < 9; i++) run_line(vecs[i]);

    // Reset in the middle of DRAIN: nothing may come out afterwards.
    set_addrs(salt);
    tick();
    n = cyc + 1;
    model_line(n, vecs[3], n + 6);
    for (int t = 0; t <= 6; t++) begin
      tick();
      drive(t, vecs[3]);
    end
    idle_inputs();
    #1 px_rst = 1'b1;
    #1;
    chk("mid_rst_addr", 32'(mem_addr_out), 0);
    chk("mid_rst_load_en", 32'(load_en), 0);
    chk("mid_rst_fetch_done", 32'(fetch_done), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    mbase = 0;
    tick(); tick();
    px_rst = 1'b0;
    repeat (10) tick();
    chk("post_rst_drained", q_le.size() + q_addr.size() + q_fd.size(), 0);
    chk("post_rst_busy", 32'(busy), 0);
    salt += 2;

    // Two full lines from a fresh rotation base, then a sparse line.
    run_line(vecs[3]);
    run_line(vecs[3]);
    run_line(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
